// File: rtl/ram_bit_access_ctrl_if.sv
// Bit-access sequencer port bundle: decoder request/response side plus the
// RAM byte port. master = decoder and RAM environment, slave = sequencer.
interface ram_bit_access_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);
    logic                     req;
    logic [2:0]               op;
    logic [7:0]               bit_addr;
    logic                     bit_in;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic                     bit_out;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_rd;
    logic                     mem_wr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output req, op, bit_addr, bit_in, mem_rdata,
        input  busy, done, err, bit_out, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  req, op, bit_addr, bit_in, mem_rdata,
        output busy, done, err, bit_out, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/ram_bit_access_ctrl.sv
// Executes 8051 bit instructions as read-modify-write byte transactions on the
// internal RAM/SFR byte port: map bit address, read byte, patch bit, write back.
module ram_bit_access_ctrl #(
    parameter int          ADDRESS_WIDTH = 8,
    parameter int          DATA_WIDTH    = 8,
    parameter int          READ_LATENCY  = 1,
    parameter logic [7:0]  BIT_AREA_BASE = 8'h20
) (
    input  logic                 clock,
    input  logic                 reset,
    ram_bit_access_ctrl_if.slave bus
);
    localparam logic [2:0] OP_RD   = 3'd0;
    localparam logic [2:0] OP_SETB = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_CPL  = 3'd3;
    localparam logic [2:0] OP_MOVB = 3'd4;
    localparam logic [2:0] OP_JBC  = 3'd5;

    // WAIT lasts READ_LATENCY-1 cycles; the counter is loaded in RD.
    localparam logic [1:0] WAIT_LOAD = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [2:0]               op_reg;
    logic [2:0]               bit_idx_reg;
    logic                     bit_in_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic                     illegal_reg;
    logic [1:0]               wait_cnt_reg;
    logic [DATA_WIDTH-1:0]    wdata_reg;
    logic                     result_reg;
    logic                     bit_hold_reg;

    logic                     op_illegal;
    logic [7:0]               byte_calc;
    logic                     old_bit;
    logic                     new_bit;
    logic                     result_bit;
    logic [DATA_WIDTH-1:0]    merged_byte;

    assign op_illegal = (bus.op > OP_JBC);

    // Low bit addresses live in the 16-byte bit area; high ones in SFRs at x0h/x8h.
    assign byte_calc = bus.bit_addr[7] ? {bus.bit_addr[7:3], 3'b000}
                                       : BIT_AREA_BASE + {4'b0000, bus.bit_addr[6:3]};

    assign old_bit = bus.mem_rdata[bit_idx_reg];

    always_comb begin
        new_bit = old_bit;
        case (op_reg)
            OP_SETB: new_bit = 1'b1;
            OP_CLR:  new_bit = 1'b0;
            OP_CPL:  new_bit = ~old_bit;
            OP_MOVB: new_bit = bit_in_reg;
            OP_JBC:  new_bit = 1'b0;
            default: new_bit = old_bit;
        endcase
    end

    assign result_bit = (op_reg == OP_RD || op_reg == OP_JBC) ? old_bit : new_bit;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_merge
            if (gi < 8) begin : g_idx
                assign merged_byte[gi] = (bit_idx_reg == 3'(gi)) ? new_bit : bus.mem_rdata[gi];
            end else begin : g_pass
                assign merged_byte[gi] = bus.mem_rdata[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.req) state_next = op_illegal ? S_DONE : S_RD;
            S_RD:   state_next = (READ_LATENCY > 1) ? S_WAIT : S_CAP;
            S_WAIT: if (wait_cnt_reg == 2'd0) state_next = S_CAP;
            S_CAP:  state_next = (op_reg == OP_RD) ? S_DONE : S_WR;
            S_WR:   state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            op_reg       <= 3'd0;
            bit_idx_reg  <= 3'd0;
            bit_in_reg   <= 1'b0;
            addr_reg     <= '0;
            illegal_reg  <= 1'b0;
            wait_cnt_reg <= 2'd0;
            wdata_reg    <= '0;
            result_reg   <= 1'b0;
            bit_hold_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && bus.req) begin
                op_reg      <= bus.op;
                bit_idx_reg <= bus.bit_addr[2:0];
                bit_in_reg  <= bus.bit_in;
                addr_reg    <= ADDRESS_WIDTH'(byte_calc);
                illegal_reg <= op_illegal;
            end
            if (state_reg == S_RD)
                wait_cnt_reg <= WAIT_LOAD;
            else if (state_reg == S_WAIT && wait_cnt_reg != 2'd0)
                wait_cnt_reg <= wait_cnt_reg - 2'd1;
            if (state_reg == S_CAP) begin
                result_reg <= result_bit;
                if (op_reg != OP_RD)
                    wdata_reg <= merged_byte;
            end
            if (state_reg == S_DONE && !illegal_reg)
                bit_hold_reg <= result_reg;
        end
    end

    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.err       = (state_reg == S_DONE) && illegal_reg;
    // The new result is presented during DONE itself and held afterwards.
    assign bus.bit_out   = (state_reg == S_DONE && !illegal_reg) ? result_reg : bit_hold_reg;
    assign bus.mem_rd    = (state_reg == S_RD);
    assign bus.mem_wr    = (state_reg == S_WR);
    assign bus.mem_addr  = (state_reg != S_IDLE) ? addr_reg : '0;
    assign bus.mem_wdata = wdata_reg;
endmodule

// File: tb/tb_ram_bit_access_ctrl.sv
// Bench for ram_bit_access_ctrl: two instances (read latency 1 and 3) on
// behavioural RAMs, directed scenarios plus random ops against a bit-level model.
module tb_ram_bit_access_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    ram_bit_access_ctrl_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) if1 ();
    ram_bit_access_ctrl_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) if3 ();

    ram_bit_access_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1), .BIT_AREA_BASE(8'h20))
        dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
    ram_bit_access_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3), .BIT_AREA_BASE(8'h20))
        dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

    int         cur_sel = 1;
    logic       req_s   = 1'b0;
    logic [2:0] op_s    = 3'd0;
    logic [7:0] ba_s    = 8'd0;
    logic       bin_s   = 1'b0;

    assign if1.req      = req_s && (cur_sel == 1);
    assign if3.req      = req_s && (cur_sel == 3);
    assign if1.op       = op_s;
    assign if3.op       = op_s;
    assign if1.bit_addr = ba_s;
    assign if3.bit_addr = ba_s;
    assign if1.bit_in   = bin_s;
    assign if3.bit_in   = bin_s;

    logic       s_busy, s_done, s_err, s_bit_out, s_mem_rd, s_mem_wr;
    logic [7:0] s_mem_addr, s_mem_wdata;
    assign s_busy      = (cur_sel == 1) ? if1.busy      : if3.busy;
    assign s_done      = (cur_sel == 1) ? if1.done      : if3.done;
    assign s_err       = (cur_sel == 1) ? if1.err       : if3.err;
    assign s_bit_out   = (cur_sel == 1) ? if1.bit_out   : if3.bit_out;
    assign s_mem_rd    = (cur_sel == 1) ? if1.mem_rd    : if3.mem_rd;
    assign s_mem_wr    = (cur_sel == 1) ? if1.mem_wr    : if3.mem_wr;
    assign s_mem_addr  = (cur_sel == 1) ? if1.mem_addr  : if3.mem_addr;
    assign s_mem_wdata = (cur_sel == 1) ? if1.mem_wdata : if3.mem_wdata;

    // Behavioural RAMs; off-latency cycles return inverted data so mistimed capture shows.
    logic       poke_en = 1'b0;
    int         poke_sel = 1;
    logic [7:0] poke_addr = 8'd0;
    logic [7:0] poke_data = 8'd0;

    logic [7:0] mem1 [0:255];
    logic [7:0] mem3 [0:255];
    logic [7:0] d1;
    logic       v1;
    logic [7:0] d3 [0:2];
    logic       v3 [0:2];

    always @(posedge clock) begin
        if (poke_en && poke_sel == 1) mem1[poke_addr] <= poke_data;
        if (if1.mem_wr) mem1[if1.mem_addr] <= if1.mem_wdata;
        v1 <= if1.mem_rd;
        d1 <= mem1[if1.mem_addr];
    end
    assign if1.mem_rdata = v1 ? d1 : ~d1;

    always @(posedge clock) begin
        if (poke_en && poke_sel == 3) mem3[poke_addr] <= poke_data;
        if (if3.mem_wr) mem3[if3.mem_addr] <= if3.mem_wdata;
        v3[0] <= if3.mem_rd;
        d3[0] <= mem3[if3.mem_addr];
        v3[1] <= v3[0];
        d3[1] <= d3[0];
        v3[2] <= v3[1];
        d3[2] <= d3[1];
    end
    assign if3.mem_rdata = v3[2] ? d3[2] : ~d3[2];

    logic overlap_seen = 1'b0;
    always @(negedge clock) begin
        if ((if1.mem_rd && if1.mem_wr) || (if3.mem_rd && if3.mem_wr)) overlap_seen <= 1'b1;
    end

    logic bm1 = 1'b0;
    logic bm3 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] ba);
        if (ba < 8'h80) return 8'h20 + ba / 8;
        return ba - ba % 8;
    endfunction

    function automatic logic exp_new(input logic [2:0] op, input logic old, input logic bin);
        case (op)
            3'd1: return 1'b1;
            3'd2: return 1'b0;
            3'd3: return !old;
            3'd4: return bin;
            3'd5: return 1'b0;
            default: return old;
        endcase
    endfunction

    task automatic poke(input int sel, input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        poke_en = 1'b1; poke_sel = sel; poke_addr = a; poke_data = d;
        @(posedge clock);
        #1 poke_en = 1'b0;
    endtask

    task automatic run_op(input string tag, input int sel, input logic [2:0] op, input logic [7:0] ba,
                          input logic bin, input logic [7:0] pre, input int hold);
        int lat, done_cyc, rd_cnt, wr_cnt, rd_cyc, wr_cyc, idx, k;
        logic [7:0] rd_addr, wdata, addr, expw, memv;
        logic bout, eout, busy_ok, old, nb, expb, prev;
        lat  = (sel == 1) ? 1 : 3;
        addr = exp_byte(ba);
        idx  = ba % 8;
        poke(sel, addr, pre);
        old  = pre[idx];
        nb   = exp_new(op, old, bin);
        expw = pre;
        expw[idx] = nb;
        expb = (op == 3'd0 || op == 3'd5) ? old : nb;
        prev = (sel == 1) ? bm1 : bm3;

        cur_sel = sel;
        @(negedge clock);
        op_s = op; ba_s = ba; bin_s = bin; req_s = 1'b1;
        done_cyc = -1; rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1;
        rd_addr = 8'd0; wdata = 8'd0; bout = 1'b0; eout = 1'b0; busy_ok = 1'b1;
        @(posedge clock);
        k = 0;
        while (k < 20 && done_cyc < 0) begin
            @(negedge clock);
            k++;
            if (k == hold) req_s = 1'b0;
            if (!s_busy) busy_ok = 1'b0;
            if (s_mem_rd) begin rd_cnt++; rd_cyc = k; rd_addr = s_mem_addr; end
            if (s_mem_wr) begin wr_cnt++; wr_cyc = k; wdata = s_mem_wdata; end
            if (s_done) begin done_cyc = k; bout = s_bit_out; eout = s_err; end
        end
        memv = (sel == 1) ? mem1[addr] : mem3[addr];

        if (op > 3'd5) begin
            chk({tag, ".done_cyc"}, done_cyc, 1);
            chk({tag, ".err"},      {31'd0, eout}, 1);
            chk({tag, ".rd_cnt"},   rd_cnt, 0);
            chk({tag, ".wr_cnt"},   wr_cnt, 0);
            chk({tag, ".bit_out"},  {31'd0, bout}, {31'd0, prev});
            expb = prev;
        end else begin
            chk({tag, ".done_cyc"}, done_cyc, (op == 3'd0) ? lat + 2 : lat + 3);
            chk({tag, ".err"},      {31'd0, eout}, 0);
            chk({tag, ".rd_cnt"},   rd_cnt, 1);
            chk({tag, ".rd_cyc"},   rd_cyc, 1);
            chk({tag, ".rd_addr"},  {24'd0, rd_addr}, {24'd0, addr});
            chk({tag, ".bit_out"},  {31'd0, bout}, {31'd0, expb});
            if (op != 3'd0) begin
                chk({tag, ".wr_cnt"},    wr_cnt, 1);
                chk({tag, ".wr_cyc"},    wr_cyc, lat + 2);
                chk({tag, ".mem_wdata"}, {24'd0, wdata}, {24'd0, expw});
                chk({tag, ".ram_byte"},  {24'd0, memv}, {24'd0, expw});
            end else begin
                chk({tag, ".wr_cnt"},    wr_cnt, 0);
                chk({tag, ".ram_byte"},  {24'd0, memv}, {24'd0, pre});
            end
        end
        chk({tag, ".busy_span"}, {31'd0, busy_ok}, 1);
        if (sel == 1) bm1 = expb; else bm3 = expb;

        @(negedge clock);
        req_s = 1'b0;
        chk({tag, ".idle_busy"},  {31'd0, s_busy}, 0);
        chk({tag, ".idle_addr"},  {24'd0, s_mem_addr}, 0);
        chk({tag, ".held_bit"},   {31'd0, s_bit_out}, {31'd0, expb});
        @(negedge clock);
        chk({tag, ".no_reaccept"}, {31'd0, s_busy}, 0);
    endtask

    initial begin
        int k;
        logic saw, any_act;
        logic [7:0] wd;

        // Reset with a request pending: nothing may be accepted.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cur_sel = 1; op_s = 3'd1; ba_s = 8'h0A; req_s = 1'b1;
        #1;
        chk("rst.busy",     {31'd0, if1.busy}, 0);
        chk("rst.done",     {31'd0, if1.done}, 0);
        chk("rst.err",      {31'd0, if1.err}, 0);
        chk("rst.bit_out",  {31'd0, if1.bit_out}, 0);
        chk("rst.mem_rd",   {31'd0, if1.mem_rd}, 0);
        chk("rst.mem_wr",   {31'd0, if1.mem_wr}, 0);
        chk("rst.mem_addr", {24'd0, if1.mem_addr}, 0);
        chk("rst.wdata",    {24'd0, if1.mem_wdata}, 0);
        chk("rst.busy3",    {31'd0, if3.busy}, 0);
        repeat (3) @(negedge clock);
        chk("rst.hold_busy", {31'd0, if1.busy}, 0);
        req_s = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rel.busy",   {31'd0, if1.busy}, 0);
        chk("rel.done",   {31'd0, if1.done}, 0);
        chk("rel.mem_rd", {31'd0, if1.mem_rd}, 0);

        // Directed scenarios.
        run_op("setb_0A",  1, 3'd1, 8'h0A, 1'b0, 8'h00, 1);
        run_op("clr_E7",   1, 3'd2, 8'hE7, 1'b0, 8'hFF, 1);
        run_op("cpl_E0",   1, 3'd3, 8'hE0, 1'b0, 8'h7E, 1);
        run_op("jbc_7F",   1, 3'd5, 8'h7F, 1'b0, 8'h80, 1);
        run_op("rd_93",    1, 3'd0, 8'h93, 1'b0, 8'h08, 1);
        run_op("ill_7",    1, 3'd7, 8'h44, 1'b1, 8'h55, 1);
        run_op("busy_req", 1, 3'd1, 8'h31, 1'b0, 8'h00, 5);
        run_op("movb_L3",  3, 3'd4, 8'h00, 1'b1, 8'hF0, 1);
        run_op("ill6_L3",  3, 3'd6, 8'hC3, 1'b0, 8'h12, 1);

        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = ($urandom_range(0, 1) == 0) ? 1 : 3;
            run_op($sformatf("rnd%0d", i), sel, 3'($urandom_range(0, 7)), 8'($urandom),
                   1'($urandom_range(0, 1)), 8'($urandom), 1);
        end

        // Reset landing in the write cycle aborts the write and the completion.
        poke(3, 8'h88, 8'h00);
        cur_sel = 3;
        @(negedge clock);
        op_s = 3'd1; ba_s = 8'h88; bin_s = 1'b0; req_s = 1'b1;
        @(posedge clock);
        saw = 1'b0; k = 0; wd = 8'd0;
        while (!saw && k < 20) begin
            @(negedge clock);
            req_s = 1'b0;
            k++;
            if (s_mem_wr) begin saw = 1'b1; wd = s_mem_wdata; end
        end
        chk("wrrst.saw_wr", {31'd0, saw}, 1);
        chk("wrrst.wr_cyc", k, 5);
        chk("wrrst.wdata",  {24'd0, wd}, 32'h01);
        reset = 1'b0;
        #1;
        chk("wrrst.mem_wr",   {31'd0, s_mem_wr}, 0);
        chk("wrrst.busy",     {31'd0, s_busy}, 0);
        chk("wrrst.done",     {31'd0, s_done}, 0);
        chk("wrrst.mem_addr", {24'd0, s_mem_addr}, 0);
        chk("wrrst.bit_out",  {31'd0, s_bit_out}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        any_act = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (s_done || s_busy || s_mem_wr) any_act = 1'b1;
        end
        chk("wrrst.quiet",    {31'd0, any_act}, 0);
        chk("wrrst.ram_byte", {24'd0, mem3[8'h88]}, 0);

        chk("rd_wr_overlap", {31'd0, overlap_seen}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_bit_access_ctrl.md
Name: ram_bit_access_ctrl

Overview:
Initiator-side sequencer for the internal RAM/SFR byte port. It executes 8051 bit instructions (MOV C,bit / JB / SETB / CLR / CPL / MOV bit,C / JBC) as read-modify-write byte transactions. It maps the 8-bit bit address to a byte address and bit index, reads the byte, and writes back the modified byte when the op requires it. It sits between the instruction decoder/ALU and the RAM byte interface.

Parameters:
ADDRESS_WIDTH, 8, RAM byte address width.
DATA_WIDTH, 8, RAM word width.
READ_LATENCY, 1, cycles from the mem_rd cycle to the cycle in which mem_rdata is valid (1..4).
BIT_AREA_BASE, 8'h20, first byte of the bit-addressable low-RAM area.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  request strobe; sampled only in IDLE
op  in  3  000 RD, 001 SETB, 010 CLR, 011 CPL, 100 MOVB (write bit_in), 101 JBC; 110/111 illegal
bit_addr  in  8  8051 bit address
bit_in  in  1  source bit for MOVB (carry)
busy  out  1  high from acceptance through the DONE cycle
done  out  1  one-cycle completion pulse
err  out  1  high with done when the op is illegal
bit_out  out  1  result bit; held until the next done
mem_addr  out  ADDRESS_WIDTH  RAM byte address
mem_rd  out  1  RAM read strobe
mem_wr  out  1  RAM write strobe
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async, active-low): state IDLE. busy, done, err, bit_out, mem_rd and mem_wr all go to 0, and mem_addr and mem_wdata go to 0, immediately regardless of clock. Reset mid-operation aborts the op with no done and no write, including while in WR.
- Address map:
  - bit_addr < 8'h80 → byte = BIT_AREA_BASE + bit_addr[6:3], bit index = bit_addr[2:0].
  - bit_addr ≥ 8'h80 → byte = {bit_addr[7:3],3'b000} (SFR ending in 0h or 8h), bit index = bit_addr[2:0].
- FSM: IDLE → RD → WAIT (READ_LATENCY-1 cycles, skipped if 1) → CAP → [WR] → DONE → IDLE.
- IDLE: when req=1 in cycle N, latch op, bit_addr and bit_in, and compute the byte address. req is ignored while busy. A new request is accepted no earlier than the cycle after DONE.
- Illegal op: IDLE → DONE at N+1 with err=1. No mem_rd or mem_wr. bit_out is unchanged.
- RD state (N+1): mem_rd=1 for exactly one cycle. mem_addr is valid and held stable through DONE.
- CAP (N+1+READ_LATENCY): capture mem_rdata and extract the old bit.
  - new bit: SETB=1, CLR=0, CPL=~old, MOVB=bit_in, JBC=0.
  - mem_wdata = captured byte with only the indexed bit replaced.
- WR (write ops only; every op except RD): mem_wr=1 for one cycle with mem_wdata. The write always occurs, even if the bit is unchanged, to keep SFR write side effects consistent.
- DONE: done=1 for one cycle. bit_out is updated in the same cycle:
  - RD and JBC → old bit.
  - All other ops → new bit.
- Latency with READ_LATENCY=1: RD op done at N+3; write ops done at N+4.
- mem_rd and mem_wr are never high in the same cycle. Only one memory transaction is outstanding at a time.
- mem_addr returns to 0 in IDLE. mem_wdata holds its last value.
- busy=1 from N+1 through the DONE cycle inclusive.

Test Plan:
1. Assert reset low mid-idle, then release → busy/done/err/bit_out/mem_rd/mem_wr=0, mem_addr=0; apply req during reset → nothing accepted.
2. SETB bit_addr=8'h0A, mem_rdata=8'h00 → mem_rd at N+1 with mem_addr=8'h21; mem_wr at N+3 with mem_wdata=8'h04; done at N+4, bit_out=1.
3. CLR bit_addr=8'hE7 (ACC.7), mem_rdata=8'hFF → mem_addr=8'hE0, mem_wdata=8'h7F, bit_out=0; CPL bit 8'hE0 on 8'h7E → mem_wdata=8'h7F.
4. JBC bit_addr=8'h7F, mem_rdata=8'h80 → mem_addr=8'h2F, mem_wdata=8'h00, bit_out=1. RD bit 8'h93 with mem_rdata=8'h08 → mem_addr=8'h90, no mem_wr, done at N+3, bit_out=1.
5. op=3'b111 → done and err at N+1, mem_rd never asserted. Second req asserted while busy → ignored, exactly one done.
6. READ_LATENCY=3, MOVB bit 8'h00 with bit_in=1 on 8'hF0 → capture at N+4, mem_wdata=8'hF1, done at N+6. Reset asserted during WR → mem_wr drops asynchronously, no done, FSM in IDLE.
